shared_mem: RTL and testbench

SHARED_MEM -- requirements
Module: shared_mem

---
 rtl/shared_mem.sv | 171 +++++++++++++++++
 tb/tb_shared_mem.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem.sv
// Word-addressed memory shared by NUM_CH requesters: a round-robin arbiter picks one
// channel, and an IDLE/BUSY/DONE sequencer completes the access after LATENCY edges.
module shared_mem #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          enable,
    input  logic [NUM_CH-1:0]          rw,
    input  logic [NUM_CH*32-1:0]       addr,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    input  logic [NUM_CH*DATA_W/8-1:0] strb,
    output logic [NUM_CH-1:0]          ready,
    output logic [NUM_CH*DATA_W-1:0]   data_out,
    output logic                       busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    cnt_q, cnt_d;
    logic [CW-1:0]                 rr_q, rr_d;
    logic [CW-1:0]                 gnt_q, gnt_d;
    logic                          rw_q, rw_d;
    logic [AW-1:0]                 idx_q, idx_d;
    logic [DATA_W-1:0]             wdata_q, wdata_d;
    logic [BW-1:0]                 wstrb_q, wstrb_d;
    logic [NUM_CH-1:0]             ready_q, ready_d;
    logic [NUM_CH-1:0][DATA_W-1:0] dout_q, dout_d;
    logic                          busy_q, busy_d;

    logic                          found;
    logic [CW-1:0]                 pick;
    logic                          sel_rw;
    logic [AW-1:0]                 sel_idx;
    logic [DATA_W-1:0]             sel_data;
    logic [BW-1:0]                 sel_strb;
    logic                          commit;
    logic                          unused_addr;

    logic [DATA_W-1:0]             mem [DEPTH];

    // Only the word-index bits of each address matter; the rest are folded away.
    assign unused_addr = ^addr;

    // Search from rr_q upward (mod NUM_CH) for the first requesting channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && enable[c] && ((int'(rr_q) + i) % NUM_CH) == c) begin
                    found = 1'b1;
                    pick  = CW'(c);
                end
            end
        end
    end

    always_comb begin
        sel_rw   = 1'b0;
        sel_idx  = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CW'(c) == pick) begin
                sel_rw   = rw[c];
                sel_idx  = addr[c*32 + 2 +: AW];
                sel_data = data_in[c*DATA_W +: DATA_W];
                sel_strb = strb[c*BW +: BW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ready_d = '0;
        dout_d  = dout_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    gnt_d   = pick;
                    rr_d    = (int'(pick) == NUM_CH - 1) ? '0 : pick + 1'b1;
                    rw_d    = sel_rw;
                    idx_d   = sel_idx;
                    wdata_d = sel_data;
                    wstrb_d = sel_strb;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (CW'(c) == gnt_q) begin
                            ready_d[c] = 1'b1;
                            if (!rw_q) begin
                                dout_d[c] = mem[idx_q];
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    // Storage survives reset; reset forces IDLE, so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (commit && rw_q) begin
            for (int b = 0; b < BW; b++) begin
                if (wstrb_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign ready    = ready_q;
    assign data_out = dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_shared_mem.sv
// Bench for shared_mem: a 2-channel default instance and a 4-channel LATENCY=1
// instance, checked against a word-array model with round-robin timing arithmetic.
module tb_shared_mem;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   en, rw, rdy;
    logic [63:0]  addr, din, dout;
    logic [7:0]   strb;
    logic         busy;

    logic [3:0]   en4, rw4, rdy4;
    logic [127:0] addr4, din4, dout4;
    logic [15:0]  strb4;
    logic         busy4;

    shared_mem #(.NUM_CH(2), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .enable(en), .rw(rw), .addr(addr), .data_in(din),
        .strb(strb), .ready(rdy), .data_out(dout), .busy(busy)
    );

    shared_mem #(.NUM_CH(4), .DATA_W(32), .DEPTH(64), .LATENCY(1)) u_dut4 (
        .clk(clk), .rst(rst), .enable(en4), .rw(rw4), .addr(addr4), .data_in(din4),
        .strb(strb4), .ready(rdy4), .data_out(dout4), .busy(busy4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_dout [2];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = widx(a);
        for (int b = 0; b < 4; b++) if (s[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // One access on the 2-channel instance; starts and ends with the sequencer idle.
    task automatic xfer(input int ch, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [31:0] rd, output logic rdy_after);
        en[ch] = 1'b1; rw[ch] = w; addr[ch*32 +: 32] = a; din[ch*32 +: 32] = d; strb[ch*4 +: 4] = s;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (rdy[ch]) lat = k;
        end
        rd = dout[ch*32 +: 32];
        en[ch] = 1'b0;
        @(posedge clk); #1;
        rdy_after = rdy[ch];
    endtask

    task automatic test_reset();
        en = '0; rw = '0; addr = '0; din = '0; strb = '0;
        en4 = '0; rw4 = '0; addr4 = '0; din4 = '0; strb4 = '0;
        #1 rst = 1'b0;
        #2;
        n_checks++; if (rdy !== 2'b00) $display("FAIL reset_ready got=%b exp=00", rdy); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (dout !== 64'h0) $display("FAIL reset_dout got=%h exp=0", dout); else n_pass++;
        n_checks++; if ({rdy4, busy4, dout4} !== '0) $display("FAIL reset_dut4 got=%h exp=0", {rdy4, busy4, dout4}); else n_pass++;
        exp_dout[0] = '0; exp_dout[1] = '0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_hold_busy got=%b exp=0", busy); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic ra;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, ra);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        n_checks++; if (lat != LAT + 1) $display("FAIL wr_latency got=%0d exp=%0d", lat - 1, LAT); else n_pass++;
        n_checks++; if (ra !== 1'b0) $display("FAIL wr_ready_width got=%b exp=0", ra); else n_pass++;
        n_checks++; if (rd !== exp_dout[0]) $display("FAIL wr_dout_unchanged got=%h exp=%h", rd, exp_dout[0]); else n_pass++;
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, ra);
        exp_dout[0] = model[widx(32'h10)];
        n_checks++; if (lat != LAT + 1) $display("FAIL rd_latency got=%0d exp=%0d", lat - 1, LAT); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", rd); else n_pass++;
        n_checks++; if (ra !== 1'b0) $display("FAIL rd_ready_width got=%b exp=0", ra); else n_pass++;
    endtask

    task automatic test_strobe();
        int lat; logic [31:0] rd; logic ra;
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, lat, rd, ra);
        model_write(32'h20, 32'hAABBCCDD, 4'hF);
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, lat, rd, ra);
        model_write(32'h20, 32'h11223344, 4'b0101);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, ra);
        exp_dout[0] = model[widx(32'h20)];
        n_checks++; if (rd !== 32'hAA22CC44) $display("FAIL strobe_merge got=%h exp=aa22cc44", rd); else n_pass++;
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic ra;
        xfer(0, 1'b1, 32'h0, 32'h5, 4'hF, lat, rd, ra);
        model_write(32'h0, 32'h5, 4'hF);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, ra);
        exp_dout[0] = model[widx(32'h1000)];
        n_checks++; if (rd !== 32'h5) $display("FAIL wrap_read got=%h exp=5", rd); else n_pass++;
    endtask

    task automatic test_drop_enable();
        int lat; logic [31:0] rd; logic ra;
        en[1] = 1'b1; rw[1] = 1'b1; addr[32 +: 32] = 32'h40; din[32 +: 32] = 32'h0BADCAFE; strb[4 +: 4] = 4'hF;
        @(posedge clk); #1;
        en[1] = 1'b0; addr[32 +: 32] = 32'h44; din[32 +: 32] = 32'h12345678;
        lat = -1;
        for (int k = 2; k <= 20 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (rdy[1]) lat = k;
        end
        n_checks++; if (lat != LAT + 1) $display("FAIL drop_en_ready got=%0d exp=%0d", lat, LAT + 1); else n_pass++;
        @(posedge clk); #1;
        model_write(32'h40, 32'h0BADCAFE, 4'hF);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, ra);
        exp_dout[1] = model[widx(32'h40)];
        n_checks++; if (rd !== exp_dout[1]) $display("FAIL drop_en_data got=%h exp=%h", rd, exp_dout[1]); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        int ch;
        rst = 1'b0;
        exp_dout[0] = '0; exp_dout[1] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        en = 2'b11; rw = 2'b00; addr = {32'h20, 32'h10};
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            ch = (k / 4) % 2;
            exp_rdy = (k % 4 == 3) ? (2'b01 << ch) : 2'b00;
            n_checks++; if (rdy !== exp_rdy) $display("FAIL rr_ready k=%0d got=%b exp=%b", k, rdy, exp_rdy); else n_pass++;
            n_checks++; if (busy !== (k % 4 != 0)) $display("FAIL rr_busy k=%0d got=%b exp=%b", k, busy, (k % 4 != 0)); else n_pass++;
            if (exp_rdy != 2'b00) begin
                exp_dout[ch] = model[widx(addr[ch*32 +: 32])];
                n_checks++;
                if (dout[ch*32 +: 32] !== exp_dout[ch]) $display("FAIL rr_data k=%0d got=%h exp=%h", k, dout[ch*32 +: 32], exp_dout[ch]);
                else n_pass++;
            end
        end
        en = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, ch, oc; bit w; logic [31:0] a, d, rd; logic [3:0] s; logic ra;
        for (int i = 0; i < 8; i++) begin
            a = 32'((24 + i) * 4); d = $urandom;
            xfer(i % 2, 1'b1, a, d, 4'hF, lat, rd, ra);
            model_write(a, d, 4'hF);
        end
        for (int i = 0; i < 40; i++) begin
            ch = int'($urandom_range(0, 1)); oc = 1 - ch; w = 1'($urandom_range(0, 1));
            a = 32'((24 + $urandom_range(0, 7)) * 4 + $urandom_range(0, 3) + $urandom_range(0, 3) * 4 * DEPTH);
            d = $urandom; s = 4'($urandom_range(0, 15));
            xfer(ch, w, a, d, s, lat, rd, ra);
            if (w) model_write(a, d, s);
            else exp_dout[ch] = model[widx(a)];
            n_checks++; if (lat != LAT + 1) $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, lat, LAT + 1); else n_pass++;
            n_checks++; if (ra !== 1'b0) $display("FAIL rand_ready_width i=%0d got=%b exp=0", i, ra); else n_pass++;
            n_checks++; if (rd !== exp_dout[ch]) $display("FAIL rand_dout i=%0d w=%0d got=%h exp=%h", i, w, rd, exp_dout[ch]); else n_pass++;
            n_checks++; if (dout[oc*32 +: 32] !== exp_dout[oc]) $display("FAIL rand_other_dout i=%0d got=%h exp=%h", i, dout[oc*32 +: 32], exp_dout[oc]); else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic ra; logic seen;
        xfer(0, 1'b1, 32'h30, 32'h0, 4'hF, lat, rd, ra);
        model_write(32'h30, 32'h0, 4'hF);
        en[0] = 1'b1; rw[0] = 1'b1; addr[0 +: 32] = 32'h30; din[0 +: 32] = 32'hCAFEF00D; strb[0 +: 4] = 4'hF;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before got=%b exp=1", busy); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (rdy !== 2'b00) $display("FAIL abort_ready got=%b exp=00", rdy); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (dout !== 64'h0) $display("FAIL abort_dout got=%h exp=0", dout); else n_pass++;
        en = 2'b00;
        exp_dout[0] = '0; exp_dout[1] = '0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy !== 2'b00) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_ready got=%b exp=0", seen); else n_pass++;
        rst = 1'b1;
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, lat, rd, ra);
        exp_dout[0] = model[widx(32'h30)];
        n_checks++; if (lat != LAT + 1) $display("FAIL abort_first_accept got=%0d exp=%0d", lat, LAT + 1); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL abort_mem_kept got=%h exp=0", rd); else n_pass++;
    endtask

    task automatic test_four_ch();
        logic [31:0] d4 [4];
        logic [3:0]  exp_rdy;
        int ch;
        for (int c = 0; c < 4; c++) begin
            d4[c] = $urandom;
            addr4[c*32 +: 32] = 32'(c * 4);
            din4[c*32 +: 32]  = d4[c];
        end
        strb4 = 16'hFFFF; rw4 = 4'hF; en4 = 4'hF;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            exp_rdy = (k % 3 == 2 && k / 3 < 4) ? (4'b0001 << (k / 3)) : 4'b0000;
            n_checks++; if (rdy4 !== exp_rdy) $display("FAIL ch4_wr_ready k=%0d got=%b exp=%b", k, rdy4, exp_rdy); else n_pass++;
            for (int c = 0; c < 4; c++) if (rdy4[c]) en4[c] = 1'b0;
        end
        en4 = 4'h0;
        @(posedge clk); #1;
        rw4 = 4'h0; en4 = 4'hF;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            ch = (k / 3) % 4;
            exp_rdy = (k % 3 == 2) ? (4'b0001 << ch) : 4'b0000;
            n_checks++; if (rdy4 !== exp_rdy) $display("FAIL ch4_rd_ready k=%0d got=%b exp=%b", k, rdy4, exp_rdy); else n_pass++;
            if (exp_rdy != 4'b0000) begin
                n_checks++;
                if (dout4[ch*32 +: 32] !== d4[ch]) $display("FAIL ch4_rd_data k=%0d got=%h exp=%h", k, dout4[ch*32 +: 32], d4[ch]);
                else n_pass++;
            end
        end
        en4 = 4'h0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_wrap();
        test_drop_enable();
        test_round_robin();
        test_random();
        test_reset_abort();
        test_four_ch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
